bram_dp: RTL and testbench

BRAM_DP -- requirements
Module: bram_dp

---
 rtl/bram_pkg.sv | 13 +
 rtl/bram_dp_clear.sv | 57 +++++
 rtl/bram_dp.sv | 134 +++++++++++++
 tb/tb_bram_dp.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared constants for the dual-port block RAM: read-during-write modes and
// the clear-sequencer state encoding.
package bram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/bram_dp_clear.sv
// Clear sequencer: sweeps zeros through every address, one word per cycle,
// starting at address 0 either after reset or on request.
module bram_dp_clear
    import bram_pkg::*;
#(
    parameter int ADDR_W         = 9,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr_req,
    output clr_state_t        o_state,
    output logic [ADDR_W-1:0] o_count,
    output logic              o_busy,
    output logic              o_zero_we
);

    clr_state_t        r_state;
    clr_state_t        w_state_next;
    logic [ADDR_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR_ON_RESET ? CLEAR : IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counter rolls from all-ones back to 0 on the final sweep write, so it
    // is already at 0 for the next sweep and never leaves the address range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_state == CLEAR) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_clr_req) w_state_next = CLEAR;
            CLEAR:   if (r_count == '1) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy    = (r_state == CLEAR);
        o_zero_we = (r_state == CLEAR);
    end

    assign o_state = r_state;
    assign o_count = r_count;

endmodule

// File: rtl/bram_dp.sv
// Simple dual-port block RAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and a built-in zeroing sweep.
module bram_dp
    import bram_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 9,
    parameter int RD_LAT         = 1,
    parameter int RDW_MODE       = 0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  clr_req,
    output logic                  busy
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    clr_state_t        w_state;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_busy;
    logic              w_zero_we;

    bram_dp_clear #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk       (clk),
        .rst       (rst),
        .i_clr_req (clr_req),
        .o_state   (w_state),
        .o_count   (w_clr_addr),
        .o_busy    (w_busy),
        .o_zero_we (w_zero_we)
    );

    assign busy = w_busy;

    logic w_wr_fire;
    logic w_rd_fire;
    assign w_wr_fire = wr_en && (w_state == IDLE);
    assign w_rd_fire = rd_en && (w_state == IDLE);

    // Single write port shared by the sweep and user writes.
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [NB-1:0]     w_mem_be;
    assign w_mem_addr = w_zero_we ? w_clr_addr : wr_addr;
    assign w_mem_data = w_zero_we ? '0 : wr_data;
    assign w_mem_be   = w_zero_we ? '1 : (w_wr_fire ? wr_be : '0);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_mem_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (w_mem_be[i]) begin
                r_mem[w_mem_addr][i*8 +: 8] <= w_mem_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_fire) begin
            r_mem_q <= r_mem[rd_addr];
        end
    end

    // Bypass lanes overlay the array output. Reset selects every lane with
    // zero data, which gives rd_data=0 without resetting the RAM register.
    logic          w_byp_hit;
    logic [NB-1:0] r_byp_be;
    logic [DATA_W-1:0] r_byp_data;
    assign w_byp_hit = (RDW_MODE == RDW_NEW) && w_wr_fire && (wr_addr == rd_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byp_be   <= '1;
            r_byp_data <= '0;
        end else if (w_rd_fire) begin
            r_byp_be   <= w_byp_hit ? wr_be : '0;
            r_byp_data <= wr_data;
        end
    end

    logic [DATA_W-1:0] w_s1_data;
    for (genvar gi = 0; gi < NB; gi++) begin : g_merge
        assign w_s1_data[gi*8 +: 8] = r_byp_be[gi] ? r_byp_data[gi*8 +: 8]
                                                   : r_mem_q[gi*8 +: 8];
    end

    logic r_v1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_rd_fire;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              r_v2;
        logic [DATA_W-1:0] r_rd_data2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v2       <= 1'b0;
                r_rd_data2 <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_rd_data2 <= w_s1_data;
                end
            end
        end

        assign rd_data  = r_rd_data2;
        assign rd_valid = r_v2;
    end else begin : g_lat1
        assign rd_data  = w_s1_data;
        assign rd_valid = r_v1;
    end

endmodule

// File: tb/tb_bram_dp.sv
// Directed bench for bram_dp: three instances (old-data, new-data, 2-cycle
// latency) share one stimulus stream.
module tb_bram_dp;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        clr_req;

    logic [15:0] rd_data_a, rd_data_b, rd_data_c;
    logic        rd_valid_a, rd_valid_b, rd_valid_c;
    logic        busy_a, busy_b, busy_c;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bram_dp #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .clr_req(clr_req), .busy(busy_a)
    );

    bram_dp #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(1), .CLEAR_ON_RESET(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .clr_req(clr_req), .busy(busy_b)
    );

    bram_dp #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(0), .CLEAR_ON_RESET(1'b1)) u_dut_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c),
        .rd_valid(rd_valid_c), .clr_req(clr_req), .busy(busy_c)
    );

    typedef struct {
        logic        wr_en;
        logic [3:0]  wr_addr;
        logic [15:0] wr_data;
        logic [1:0]  wr_be;
        logic        rd_en;
        logic [3:0]  rd_addr;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                                input logic [1:0] be, input logic re, input logic [3:0] ra,
                                input logic [15:0] ea, input logic [15:0] eb);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.wr_be = be;
        v.rd_en = re; v.rd_addr = ra; v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a sample point; counts cycles with busy high, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy_a && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_one(input logic [3:0] addr, input logic [15:0] exp, input string name);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = addr;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        check({name, "_valid"}, rd_valid_a, 1);
        check({name, "_data"}, rd_data_a, exp);
        $display("read addr %0d -> valid=%0b data=0x%04h", addr, rd_valid_a, rd_data_a);
    endtask

    initial begin
        int n;
        logic [15:0] lat_exp [3];

        for (int i = 0; i < 16; i++) vecs[i] = mk(0, 0, 0, 0, 1, 4'(i), 16'h0000, 16'h0000);
        vecs[16] = mk(1, 3, 16'hABCD, 2'b11, 0, 0, 16'h0000, 16'h0000);
        vecs[17] = mk(1, 3, 16'h1234, 2'b01, 0, 0, 16'h0000, 16'h0000);
        vecs[18] = mk(0, 0, 16'h0000, 2'b00, 1, 3, 16'hAB34, 16'hAB34);
        vecs[19] = mk(1, 7, 16'h5555, 2'b00, 0, 0, 16'hAB34, 16'hAB34);
        vecs[20] = mk(0, 0, 16'h0000, 2'b00, 1, 7, 16'h0000, 16'h0000);
        vecs[21] = mk(1, 5, 16'h1111, 2'b11, 0, 0, 16'h0000, 16'h0000);
        vecs[22] = mk(1, 5, 16'h22FF, 2'b10, 1, 5, 16'h1111, 16'h2211);
        vecs[23] = mk(0, 0, 16'h0000, 2'b00, 1, 5, 16'h2211, 16'h2211);
        vecs[24] = mk(1, 8, 16'h00AA, 2'b11, 1, 3, 16'hAB34, 16'hAB34);
        vecs[25] = mk(0, 0, 16'h0000, 2'b00, 1, 8, 16'h00AA, 16'h00AA);
        vecs[26] = mk(1, 0, 16'h0A0A, 2'b11, 0, 0, 16'h00AA, 16'h00AA);
        vecs[27] = mk(1, 1, 16'h1B1B, 2'b11, 0, 0, 16'h00AA, 16'h00AA);
        vecs[28] = mk(1, 2, 16'h2C2C, 2'b11, 0, 0, 16'h00AA, 16'h00AA);
        lat_exp[0] = 16'h0A0A; lat_exp[1] = 16'h1B1B; lat_exp[2] = 16'h2C2C;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0; clr_req = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_a, 1);
        check("rst_rd_valid", rd_valid_a, 0);
        check("rst_rd_data", rd_data_a, 0);
        check("rst_lat2_valid", rd_valid_c, 0);
        check("rst_lat2_data", rd_data_c, 0);

        // Post-reset sweep length
        @(negedge clk);
        rst = 1'b0;
        #1;
        count_busy(n);
        check("reset_clear_busy_cycles", n, 16);
        $display("reset sweep: busy for %0d cycles", n);

        // Table: each vector's read (if any) is checked one cycle later
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
            wr_be = vecs[i].wr_be; rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), rd_valid_a, vecs[i].rd_en);
            check($sformatf("vec%0d_data_rdw0", i), rd_data_a, vecs[i].exp_a);
            check($sformatf("vec%0d_data_rdw1", i), rd_data_b, vecs[i].exp_b);
            $display("vec %0d: wr=%0b a=%0d d=0x%04h be=%02b rd=%0b a=%0d -> v=%0b d0=0x%04h d1=0x%04h",
                     i, vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data, vecs[i].wr_be,
                     vecs[i].rd_en, vecs[i].rd_addr, rd_valid_a, rd_data_a, rd_data_b);
        end
        wr_en = 1'b0; rd_en = 1'b0;

        // Two-cycle latency, back-to-back reads of 0,1,2
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rd_en = (k < 3); rd_addr = 4'(k);
            @(posedge clk);
            #1;
            if (k == 0) begin
                check("lat2_not_yet_valid", rd_valid_c, 0);
                check("lat1_first_valid", rd_valid_a, 1);
            end else if (k <= 3) begin
                check($sformatf("lat2_valid_%0d", k), rd_valid_c, 1);
                check($sformatf("lat2_data_%0d", k), rd_data_c, lat_exp[k-1]);
            end else begin
                check("lat2_valid_end", rd_valid_c, 0);
                check("lat2_data_hold", rd_data_c, 16'h2C2C);
            end
            $display("lat2 step %0d: rd_en=%0b -> valid=%0b data=0x%04h", k, rd_en, rd_valid_c, rd_data_c);
        end
        rd_en = 1'b0;

        // Clear request with an in-flight read, blocked traffic and a repeat request
        @(negedge clk);
        clr_req = 1'b1; rd_en = 1'b1; rd_addr = 4'd3;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        check("clr_busy_start", busy_a, 1);
        check("clr_inflight_valid", rd_valid_a, 1);
        check("clr_inflight_data", rd_data_a, 16'hAB34);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; wr_be = 2'b11;
        n = 1;
        while (busy_a && n < 40) begin
            clr_req = (n == 8);
            @(posedge clk);
            #1;
            if (busy_a) begin
                n++;
                check($sformatf("clr_no_valid_%0d", n), rd_valid_a, 0);
            end
        end
        check("clr_after_no_valid", rd_valid_a, 0);
        wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
        check("clr_busy_cycles", n, 16);
        $display("clear request: busy for %0d cycles", n);
        read_one(4'd0, 16'h0000, "clr_ignored_write_a0");
        read_one(4'd3, 16'h0000, "clr_zeroed_a3");

        // Reset in the middle of a sweep
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h7777; wr_be = 2'b11;
        @(negedge clk);
        wr_en = 1'b0; clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        n = 1;
        while (busy_a && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midclr_reached_addr7", n, 8);
        #2;
        rst = 1'b1;
        #1;
        check("midclr_busy_in_reset", busy_a, 1);
        check("midclr_valid_in_reset", rd_valid_a, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        count_busy(n);
        check("midclr_restart_busy_cycles", n, 16);
        $display("reset mid-sweep: busy for %0d cycles after release", n);
        read_one(4'd3, 16'h0000, "midclr_zeroed_a3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
